tick_gen: RTL and testbench
===========================

# tick_gen

Parametrised two-stage tick generator: successor to the fixed 14-bit cascaded divider. A fixed prescaler is followed by a runtime-programmable main divider. The block adds enable/freeze, stop, periodic and one-shot modes, a shadowed divisor load, and a square-wave output. It sits between the board clock and the light-flow/display sequencers, which consume `tick` as a single-cycle strobe.

## Interface
- PRE_W, 14: prescaler counter width.
- PRE_DIV, 10000: prescaler period in clk cycles; legal range 2..2^PRE_W.
- CNT_W, 14: main counter, divisor and count width.
- DIV_RST, 10000: reset value of the active divisor; legal range 1..2^CNT_W-1.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; low freezes all counters and state.
- mode  in  1  0 = periodic, 1 = one-shot; latched on IDLE->RUN.
- start  in  1  one-shot trigger, sampled in IDLE only.
- stop  in  1  abort to IDLE; highest priority.
- div_in  in  CNT_W  new main divisor.
- div_load  in  1  capture strobe for div_in.
- div_cur  out  CNT_W  active divisor D.
- cnt  out  CNT_W  main count, 0..D-1.
- pre_tick  out  1  prescaler terminal strobe.
- tick  out  1  registered one-cycle period strobe.
- sq  out  1  toggles on every tick, giving a square wave of period 2*PRE_DIV*D.
- busy  out  1  high in RUN.

## Operation
- States: IDLE and RUN. Reset puts the block in IDLE.
- Transitions, all qualified by en=1 and stop=0:
  - IDLE->RUN when mode=0, or when mode=1 and start=1.
  - RUN->IDLE at a one-shot wrap.
  - Any state->IDLE when stop=1, regardless of en.
- Prescaler: pre_cnt counts 0..PRE_DIV-1 in RUN with en=1.
  - pre_tick = busy & en & (pre_cnt==PRE_DIV-1), decoded from registers.
- Main counter: advances on each pre_tick.
  - On pre_tick with cnt==D-1, cnt wraps to 0; this is the wrap event.
  - At a wrap: tick<=1 for the next cycle and sq toggles.
  - In one-shot mode the state also returns to IDLE at the wrap.
- Divisor load:
  - div_load captures div_in into a shadow register; div_in==0 is stored as 1.
  - In IDLE, div_cur takes the new value at the next edge.
  - In RUN, the new value is applied at the next wrap edge. A load coinciding with a wrap edge applies at that edge (bypass).
  - Later loads before the wrap overwrite the shadow; the last one wins.
- Entering IDLE, by stop or one-shot completion, clears pre_cnt and cnt.
  - sq and div_cur are kept.
  - stop suppresses a tick that would occur on the same edge.
- start while in RUN is ignored. A mode change is ignored until the next IDLE->RUN.
- en=0: counters, state and sq hold, and tick/pre_tick are 0. stop still acts.
- Width rule: compare counters against D-1 and PRE_DIV-1 computed at full width, with no truncation.

## Timing
- Reset values (asynchronous, on rst low): tick=0, pre_tick=0, sq=0, busy=0, cnt=0, div_cur=DIV_RST, shadow=DIV_RST, state IDLE.
- Start latency: with start (or mode=0) sampled at edge E0, busy=1 after E0.
  - tick is high for exactly the one cycle after edge E0+PRE_DIV*D, provided en was held high.
- Periodic mode: consecutive ticks are exactly PRE_DIV*D cycles apart.
  - Each en-low cycle stretches the current period by one cycle.
- One-shot mode: busy falls on the same edge that raises tick. A new start is accepted from the following cycle.
- div_load latency: 1 edge in IDLE; in RUN, it takes effect at the wrap edge ending the current period.
- rst low mid-period: all outputs return to reset values immediately, with no partial tick.

## Test plan
Bench parameters: PRE_DIV=4, DIV_RST=3.
- Reset: rst low during RUN with cnt=2 -> tick=0, busy=0, cnt=0, div_cur=3 with no clock edge; after release, state IDLE.
- Periodic: mode=0, en=1 from E0 -> tick high after E12, E24 and E36; sq=1,0,1; pre_tick every 4 cycles.
- One-shot: mode=1, start pulse at E0 -> single tick after E12 and busy 1->0 at E12; start at E5 ignored; no tick at E24.
- Divisor load: div_load with div_in=5 at E6 -> period ending at E12 unchanged, next tick at E32. Then div_in=0 -> div_cur=1, 4-cycle period.
- Freeze and stop: en=0 for 7 cycles mid-period -> period 19 cycles. stop on a wrap edge -> no tick, busy=0, cnt=0, pre_cnt=0, sq unchanged.

Source files
------------

// File: rtl/tick_gen_if.sv
// Control/status bundle between a sequencer (master) and tick_gen (slave).
interface tick_gen_if #(
   parameter int CNT_W = 14
);
   logic             en;
   logic             mode;
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic [CNT_W-1:0] div_cur;
   logic [CNT_W-1:0] cnt;
   logic             pre_tick;
   logic             tick;
   logic             sq;
   logic             busy;

   modport master (
      output en, mode, start, stop, div_in, div_load,
      input  div_cur, cnt, pre_tick, tick, sq, busy
   );

   modport slave (
      input  en, mode, start, stop, div_in, div_load,
      output div_cur, cnt, pre_tick, tick, sq, busy
   );
endinterface

// File: rtl/tick_gen.sv
// Two-stage tick generator: fixed prescaler feeding a programmable main divider,
// with periodic/one-shot modes, freeze, stop and a shadowed divisor.
//
// state | meaning
// IDLE  | counters cleared, divisor follows the shadow register directly
// RUN   | prescaler and main counter advance while en is high
module tick_gen #(
   parameter int PRE_W   = 14,
   parameter int PRE_DIV = 10000,
   parameter int CNT_W   = 14,
   parameter int DIV_RST = 10000
) (
   input logic       clk,
   input logic       rst,
   tick_gen_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [PRE_W:0]   PRE_LAST = (PRE_W+1)'(PRE_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W:0]   WIDE_ONE = 1;
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);

   state_t           state, state_nx;
   logic             mode_q, mode_nx;
   logic [PRE_W-1:0] pre_cnt, pre_cnt_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] div_cur, div_nx;
   logic [CNT_W-1:0] shadow, shadow_nx;
   logic             tick, tick_nx;
   logic             sq, sq_nx;
   logic [CNT_W:0]   div_last;
   logic             pre_hit, cnt_hit, wrap;

   // Terminal compares are done one bit wider so D-1 never wraps around.
   always_comb begin
      div_last = {1'b0, div_cur} - WIDE_ONE;
      pre_hit  = (state == RUN) && bus.en && ({1'b0, pre_cnt} == PRE_LAST);
      cnt_hit  = ({1'b0, cnt} == div_last);
      wrap     = pre_hit && cnt_hit && !bus.stop;
   end

   always_comb begin
      state_nx   = state;
      mode_nx    = mode_q;
      pre_cnt_nx = pre_cnt;
      cnt_nx     = cnt;
      div_nx     = div_cur;
      sq_nx      = sq;
      tick_nx    = 1'b0;
      shadow_nx  = shadow;

      if (bus.div_load)
         shadow_nx = (bus.div_in == '0) ? CNT_ONE : bus.div_in;

      // Bypass: a load on the wrap edge itself is applied at that edge.
      if ((state == IDLE) || wrap)
         div_nx = shadow_nx;

      if (bus.stop) begin
         state_nx   = IDLE;
         pre_cnt_nx = '0;
         cnt_nx     = '0;
      end else if (bus.en) begin
         case (state)
            IDLE: begin
               if (!bus.mode || bus.start) begin
                  state_nx = RUN;
                  mode_nx  = bus.mode;
               end
            end
            RUN: begin
               if (pre_hit) begin
                  pre_cnt_nx = '0;
                  if (cnt_hit) begin
                     cnt_nx  = '0;
                     tick_nx = 1'b1;
                     sq_nx   = ~sq;
                     if (mode_q)
                        state_nx = IDLE;
                  end else begin
                     cnt_nx = cnt + CNT_ONE;
                  end
               end else begin
                  pre_cnt_nx = pre_cnt + PRE_ONE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         mode_q  <= 1'b0;
         pre_cnt <= '0;
         cnt     <= '0;
         div_cur <= DIV_INIT;
         shadow  <= DIV_INIT;
         tick    <= 1'b0;
         sq      <= 1'b0;
      end else begin
         state   <= state_nx;
         mode_q  <= mode_nx;
         pre_cnt <= pre_cnt_nx;
         cnt     <= cnt_nx;
         div_cur <= div_nx;
         shadow  <= shadow_nx;
         tick    <= tick_nx;
         sq      <= sq_nx;
      end
   end

   assign bus.div_cur  = div_cur;
   assign bus.cnt      = cnt;
   assign bus.pre_tick = pre_hit;
   assign bus.tick     = tick;
   assign bus.sq       = sq;
   assign bus.busy     = (state == RUN);
endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed scenarios plus random stimulus against a phase-based model.
module tb_tick_gen;
   localparam int PRE_W   = 3;
   localparam int PRE_DIV = 4;
   localparam int CNT_W   = 8;
   localparam int DIV_RST = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tick_gen_if #(.CNT_W(CNT_W)) bus ();

   tick_gen #(
      .PRE_W(PRE_W), .PRE_DIV(PRE_DIV), .CNT_W(CNT_W), .DIV_RST(DIV_RST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int edges = 0;
   int base  = 0;
   int tick_q[$];

   // Model: one phase counter across the whole period, 0..PRE_DIV*D-1.
   bit m_busy, m_one, m_sq, m_tick;
   int m_phase, m_d, m_shadow;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_one = 0; m_sq = 0; m_tick = 0;
      m_phase = 0; m_d = DIV_RST; m_shadow = DIV_RST;
   endtask

   task automatic model_check();
      chk("busy", bus.busy, m_busy);
      chk("tick", bus.tick, m_tick);
      chk("sq", bus.sq, m_sq);
      chk("div_cur", bus.div_cur, m_d);
      chk("cnt", bus.cnt, m_phase / PRE_DIV);
      chk("pre_tick", bus.pre_tick,
          m_busy && bus.en && ((m_phase % PRE_DIV) == PRE_DIV - 1));
   endtask

   task automatic model_update();
      int sh;
      bit w;
      sh = m_shadow;
      if (bus.div_load) sh = (bus.div_in == 0) ? 1 : int'(bus.div_in);
      w = m_busy && bus.en && !bus.stop && (m_phase == PRE_DIV * m_d - 1);
      if (!m_busy || w) m_d = sh;
      m_shadow = sh;
      m_tick = w;
      if (bus.stop) begin
         m_busy = 0;
         m_phase = 0;
      end else if (bus.en) begin
         if (!m_busy) begin
            if (!bus.mode || bus.start) begin
               m_busy = 1; m_one = bus.mode; m_phase = 0;
            end
         end else if (w) begin
            m_phase = 0;
            m_sq = !m_sq;
            if (m_one) m_busy = 0;
         end else begin
            m_phase++;
         end
      end
   endtask

   // Check at negedge, advance model, then let the DUT take the same edge.
   task automatic step();
      @(negedge clk);
      model_check();
      if (bus.tick) tick_q.push_back(edges - base - 1);
      model_update();
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic do_reset();
      bus.en = 0; bus.mode = 0; bus.start = 0; bus.stop = 0;
      bus.div_load = 0; bus.div_in = '0;
      rst = 0;
      #2;
      chk("rst_tick", bus.tick, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cnt", bus.cnt, 0);
      chk("rst_div", bus.div_cur, DIV_RST);
      chk("rst_sq", bus.sq, 0);
      chk("rst_pre", bus.pre_tick, 0);
      model_reset();
      @(posedge clk);
      edges++;
      #1;
      rst = 1;
   endtask

   task automatic chk_ticks(input string tag, input int exp[$]);
      chk({tag, "_n"}, tick_q.size(), exp.size());
      foreach (exp[i])
         chk({tag, "_t"}, (i < tick_q.size()) ? tick_q[i] : -1, exp[i]);
   endtask

   initial begin
      rst = 1;
      #1;
      do_reset();

      // Periodic: ticks after E12, E24, E36
      tick_q.delete();
      bus.en = 1; bus.mode = 0;
      base = edges;
      repeat (40) step();
      chk_ticks("periodic", '{12, 24, 36});

      // Async reset mid-period with cnt=2
      do_reset();
      bus.en = 1; bus.mode = 0;
      repeat (10) step();
      chk("mid_cnt", bus.cnt, 2);
      chk("mid_busy", bus.busy, 1);
      do_reset();
      step();
      chk("post_rst_idle", bus.busy, 0);

      // One-shot: start at E0, re-start at E5 ignored
      do_reset();
      tick_q.delete();
      bus.en = 1; bus.mode = 1;
      base = edges;
      for (int e = 0; e < 30; e++) begin
         bus.start = (e == 0 || e == 5);
         step();
         if (e == 11) chk("os_busy_e11", bus.busy, 1);
         if (e == 12) chk("os_busy_e12", bus.busy, 0);
      end
      bus.start = 0;
      chk_ticks("oneshot", '{12});

      // Divisor load: 5 at E6 applies at E12, 0 at E33 applies at E52
      do_reset();
      tick_q.delete();
      bus.en = 1; bus.mode = 0;
      base = edges;
      for (int e = 0; e < 64; e++) begin
         bus.div_load = (e == 6 || e == 33);
         bus.div_in   = (e == 6) ? CNT_W'(5) : '0;
         step();
      end
      bus.div_load = 0;
      chk_ticks("divload", '{12, 32, 52, 56, 60});
      chk("div_zero", bus.div_cur, 1);

      // Freeze for 7 cycles, then stop on the next wrap edge
      do_reset();
      tick_q.delete();
      bus.mode = 0;
      base = edges;
      for (int e = 0; e < 40; e++) begin
         bus.en   = !(e >= 5 && e < 12);
         bus.stop = (e == 31);
         step();
         if (e == 31) begin
            chk("stop_busy", bus.busy, 0);
            chk("stop_cnt", bus.cnt, 0);
            chk("stop_sq", bus.sq, 1);
            chk("stop_tick", bus.tick, 0);
         end
      end
      bus.stop = 0;
      chk_ticks("freeze", '{19});

      // Random stimulus
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ((i % 700) == 699) do_reset();
         bus.en       = ($urandom_range(0, 9) != 0);
         bus.stop     = ($urandom_range(0, 49) == 0);
         bus.start    = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 19) == 0) bus.mode = 1'($urandom_range(0, 1));
         bus.div_load = ($urandom_range(0, 24) == 0);
         bus.div_in   = CNT_W'($urandom_range(0, 5));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
